lieat_ifu_bpuque: RTL and testbench
===================================

# lieat_ifu_bpuque

In-flight branch queue between the IFU predictor lookup and EXU branch resolution. On every conditional-branch fetch it records the predictor index and the predicted direction in a FIFO. When the EXU resolves branches in program order, it pops the oldest entry and drives the predictor's training port (`callback_en`/`callback_index`/`callback_result`). On a misprediction it raises `mispredict` and discards every younger in-flight entry.

## Interface
- `DEPTH`, 4, number of in-flight branch entries; power of two, ≥2
- `IDX_W`, 5, predictor index width
- `clk` in 1: clock; all state changes on rising edge
- `rst` in 1: reset, synchronous, active-high
- `prdt_valid` in 1: IFU has a predicted conditional branch this cycle
- `prdt_ready` out 1: queue can accept; `= (count != DEPTH)`
- `prdt_index` in IDX_W: predictor index used for the lookup
- `prdt_taken` in 1: predicted direction (predictor `bxx_taken`)
- `rslv_valid` in 1: EXU resolved the oldest in-flight branch
- `rslv_taken` in 1: actual direction
- `flush` in 1: external pipeline flush (trap/redirect); empties the queue
- `callback_en` out 1: training strobe to predictor
- `callback_index` out IDX_W: index of resolved branch
- `callback_result` out 1: actual direction of resolved branch
- `mispredict` out 1: one-cycle pulse; resolved direction ≠ predicted
- `rslv_err` out 1: one-cycle pulse; resolve arrived while queue empty
- `count` out clog2(DEPTH+1): current occupancy

## Operation
- Storage: DEPTH entries of {index, taken}; read pointer `rp` and write pointer `wp` are clog2(DEPTH) bits and wrap modulo DEPTH; `count` is tracked separately.
- Push condition: `prdt_valid & prdt_ready` writes the entry at `wp` and increments `wp`. There is no full-bypass; when full, `prdt_ready=0` even if a pop occurs in the same cycle.
- Pop condition: `rslv_valid & (count!=0)` reads the entry at `rp` and increments `rp`. Registered outputs next cycle:
  - `callback_en=1`
  - `callback_index=entry.index`
  - `callback_result=rslv_taken`
  - `mispredict=(rslv_taken != entry.taken)`
- Resolve while empty: `rslv_valid & (count==0)` produces no callback and no pointer change. It registers `rslv_err=1`.
- Misprediction on pop:
  - Next state is empty: `rp=wp=0`, `count=0`.
  - A push in the same cycle is dropped, because it is a wrong-path fetch.
  - The callback for the mispredicted branch is still issued.
- `flush`:
  - Next state is empty and any same-cycle push is dropped.
  - A same-cycle valid pop still produces its callback and `mispredict` value, since resolution is architectural.
  - Flush and mispredict together result in empty.
- Simultaneous push and pop without mispredict or flush: `count` is unchanged and both pointers advance. This includes the case count==1 (head popped, new entry written).
- Count update: count += push_accepted − pop_done. It never exceeds DEPTH and never underflows.
- `callback_index` and `callback_result` hold their last value when `callback_en=0`. Consumers sample them only with `callback_en`.

## Timing
- Reset (rst=1 at an edge):
  - `count=0`, `rp=wp=0`
  - `callback_en=0`, `callback_index=0`, `callback_result=0`, `mispredict=0`, `rslv_err=0`
  - `prdt_ready=1` from the first cycle after reset
  - Reset takes priority over push, pop and flush.
  - Reset mid-operation discards all entries; no callback is issued for them.
- `prdt_ready` is combinational from `count` only. It has no dependence on `prdt_valid` or `rslv_valid`.
- Resolve latency: `rslv_valid` at cycle N → `callback_en`/`mispredict` at N+1, for exactly one cycle per pop.
- Back-to-back resolves on consecutive cycles produce consecutive callback strobes.
- Push at cycle N is visible in `count` at N+1. The earliest pop of that entry is at N+1.
- `mispredict` at N+1 coincides with `count==0` at N+1.

## Test plan
- Reset, then push idx 3/T, 7/N, 12/T; resolve T,N,T on three consecutive cycles → three `callback_en` pulses in cycles N+1..N+3 with idx 3/1, 7/0, 12/1; `mispredict` stays 0; final `count=0`.
- Fill DEPTH=4 entries → `prdt_ready=0`; push held high while full is not accepted and `count` stays 4. Resolve once → `prdt_ready=1` the next cycle. Repeat for 3 fill/drain rounds to exercise pointer wrap.
- Push idx 5/T, 9/T, 2/N; resolve N for idx 5 while simultaneously pushing idx 30 → callback idx 5/0 with `mispredict=1`; `count=0` next cycle; idx 30 dropped; the next resolve gives `rslv_err=1` and no callback.
- count=2, then `flush` together with `rslv_valid` (rslv_taken = predicted) → callback for the head is issued, `mispredict=0`, and `count=0` next cycle.
- count=1, push idx 17/N and resolve the head in the same cycle → `count` stays 1; the next resolve produces a callback for idx 17.
- Assert `rst` with count=3 and `rslv_valid=1` → no callback next cycle; all outputs at reset values; `prdt_ready=1`.

Source files
------------

// File: rtl/lieat_ifu_bpuque.sv
// In-flight conditional-branch queue between IFU prediction and EXU resolution.
// Pops in program order, drives predictor training, and squashes younger entries on mispredict.
module lieat_ifu_bpuque #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         prdt_valid,
    output logic                         prdt_ready,
    input  logic [IDX_W-1:0]             prdt_index,
    input  logic                         prdt_taken,
    input  logic                         rslv_valid,
    input  logic                         rslv_taken,
    input  logic                         flush,
    output logic                         callback_en,
    output logic [IDX_W-1:0]             callback_index,
    output logic                         callback_result,
    output logic                         mispredict,
    output logic                         rslv_err,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [IDX_W-1:0] idx_mem [DEPTH];
    logic [DEPTH-1:0] tkn_mem;

    logic [PTR_W-1:0] rp_q, rp_d;
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             cb_en_q;
    logic [IDX_W-1:0] cb_idx_q, cb_idx_d;
    logic             cb_res_q, cb_res_d;
    logic             mis_q, err_q;

    logic             push, pop, empty, mis, kill, wr_en, err;
    logic [IDX_W-1:0] head_idx;
    logic             head_tkn;

    assign prdt_ready = (cnt_q != CNT_W'(DEPTH));
    assign empty      = (cnt_q == '0);
    assign head_idx   = idx_mem[rp_q];
    assign head_tkn   = tkn_mem[rp_q];

    always_comb begin
        push     = prdt_valid & prdt_ready;
        pop      = rslv_valid & ~empty;
        err      = rslv_valid & empty;
        mis      = pop & (rslv_taken != head_tkn);
        // Mispredict or flush means every still-queued entry is wrong-path.
        kill     = mis | flush;
        wr_en    = push & ~kill;
        rp_d     = rp_q;
        wp_d     = wp_q;
        cnt_d    = cnt_q;
        cb_idx_d = cb_idx_q;
        cb_res_d = cb_res_q;

        if (pop) begin
            cb_idx_d = head_idx;
            cb_res_d = rslv_taken;
        end

        if (kill) begin
            rp_d  = '0;
            wp_d  = '0;
            cnt_d = '0;
        end else begin
            if (pop) begin
                rp_d = rp_q + PTR_W'(1);
            end
            if (push) begin
                wp_d = wp_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rp_q     <= '0;
            wp_q     <= '0;
            cnt_q    <= '0;
            cb_en_q  <= 1'b0;
            cb_idx_q <= '0;
            cb_res_q <= 1'b0;
            mis_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rp_q     <= rp_d;
            wp_q     <= wp_d;
            cnt_q    <= cnt_d;
            cb_en_q  <= pop;
            cb_idx_q <= cb_idx_d;
            cb_res_q <= cb_res_d;
            mis_q    <= mis;
            err_q    <= err;
        end
    end

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            idx_mem[wp_q] <= prdt_index;
            tkn_mem[wp_q] <= prdt_taken;
        end
    end

    assign callback_en     = cb_en_q;
    assign callback_index  = cb_idx_q;
    assign callback_result = cb_res_q;
    assign mispredict      = mis_q;
    assign rslv_err        = err_q;
    assign count           = cnt_q;

endmodule

// File: tb/tb_lieat_ifu_bpuque.sv
// Scoreboard bench for lieat_ifu_bpuque: a queue-based reference model predicts every cycle's
// registered outputs; a separate monitor pops and compares them.
module tb_lieat_ifu_bpuque;

    localparam int DEPTH = 4;
    localparam int IDX_W = 5;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst, prdt_valid, prdt_taken, rslv_valid, rslv_taken, flush;
    logic [IDX_W-1:0] prdt_index;
    logic             prdt_ready, callback_en, callback_result, mispredict, rslv_err;
    logic [IDX_W-1:0] callback_index;
    logic [CNT_W-1:0] count;

    lieat_ifu_bpuque #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .prdt_valid      (prdt_valid),
        .prdt_ready      (prdt_ready),
        .prdt_index      (prdt_index),
        .prdt_taken      (prdt_taken),
        .rslv_valid      (rslv_valid),
        .rslv_taken      (rslv_taken),
        .flush           (flush),
        .callback_en     (callback_en),
        .callback_index  (callback_index),
        .callback_result (callback_result),
        .mispredict      (mispredict),
        .rslv_err        (rslv_err),
        .count           (count)
    );

    always #5 clk = ~clk;

    typedef struct {int idx; bit tkn;} ent_t;
    typedef struct {bit en; int idx; bit res; bit mis; bit err; int cnt;} exp_t;

    ent_t m_q[$];
    exp_t exp_q[$];
    int   h_idx = 0;
    bit   h_res = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   running = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, derive the expected outputs for the next cycle.
    task automatic step(input bit rs, input bit pv, input int pi, input bit pt,
                        input bit rv, input bit rt, input bit fl);
        exp_t e;
        ent_t hd;
        bit   push, pop, mis;
        rst = rs; prdt_valid = pv; prdt_index = IDX_W'(pi); prdt_taken = pt;
        rslv_valid = rv; rslv_taken = rt; flush = fl;
        e = '{en: 0, idx: 0, res: 0, mis: 0, err: 0, cnt: 0};
        if (rs) begin
            m_q.delete();
            h_idx = 0;
            h_res = 0;
        end else begin
            push  = pv && (m_q.size() < DEPTH);
            pop   = rv && (m_q.size() > 0);
            e.err = rv && (m_q.size() == 0);
            mis   = 0;
            if (pop) begin
                hd    = m_q.pop_front();
                mis   = (rt != hd.tkn);
                h_idx = hd.idx;
                h_res = rt;
                e.en  = 1;
            end
            if (mis || fl) m_q.delete();
            else if (push) m_q.push_back('{idx: pi, tkn: pt});
            e.mis = mis;
        end
        e.idx = h_idx;
        e.res = h_res;
        e.cnt = m_q.size();
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push1(input int i, input bit t);
        step(0, 1, i, t, 0, 0, 0);
    endtask

    task automatic rslv(input bit t);
        step(0, 0, 0, 0, 1, t, 0);
    endtask

    // Resolve the head as predicted (model queue holds the prediction).
    task automatic rslv_ok();
        rslv(m_q.size() > 0 ? m_q[0].tkn : 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (running) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard: no expected entry, got none, expected one");
                end else begin
                    e = exp_q.pop_front();
                    chk("callback_en", int'(callback_en), int'(e.en));
                    chk("callback_index", int'(callback_index), e.idx);
                    chk("callback_result", int'(callback_result), int'(e.res));
                    chk("mispredict", int'(mispredict), int'(e.mis));
                    chk("rslv_err", int'(rslv_err), int'(e.err));
                    chk("count", int'(count), e.cnt);
                    chk("prdt_ready", int'(prdt_ready), int'(e.cnt != DEPTH));
                end
            end
        end
    end

    initial begin : stimulus
        bit pv, rv, rt, fl, rs;
        running = 1;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // In-order resolution, all correct.
        push1(3, 1); push1(7, 0); push1(12, 1);
        rslv(1); rslv(0); rslv(1);
        idle(); idle();

        // Fill/drain rounds with full-hold and pointer wrap.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < DEPTH; k++) push1(int'($urandom_range(0, 31)), 1'($urandom));
            push1(25, 1); push1(26, 0);
            rslv_ok();
            idle();
            for (int k = 0; k < DEPTH - 1; k++) rslv_ok();
            idle();
        end

        // Mispredict with same-cycle push, then resolve on empty.
        push1(5, 1); push1(9, 1); push1(2, 0);
        step(0, 1, 30, 1, 1, 0, 0);
        idle();
        rslv(1);
        idle();

        // Flush alongside a correct resolve.
        push1(10, 1); push1(11, 0);
        step(0, 0, 0, 0, 1, 1, 1);
        idle();

        // Push and pop together at count==1.
        push1(20, 1);
        step(0, 1, 17, 0, 1, 1, 0);
        rslv(0);
        idle();

        // Reset mid-operation with a resolve pending.
        push1(1, 1); push1(2, 1); push1(3, 0);
        step(1, 0, 0, 0, 1, 1, 0);
        idle(); idle();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rs = ($urandom_range(0, 299) == 0);
            fl = ($urandom_range(0, 39) == 0);
            pv = ($urandom_range(0, 2) != 0);
            rv = ($urandom_range(0, 2) == 0);
            if (m_q.size() > 0 && $urandom_range(0, 7) != 0) rt = m_q[0].tkn;
            else rt = 1'($urandom);
            step(rs, pv, int'($urandom_range(0, 31)), 1'($urandom), rv, rt, fl);
        end
        idle(); idle();

        running = 0;
        chk("scoreboard_leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
